// File: rtl/des_key_sched_dec_pkg.sv
// des_pkg: DES key-schedule tables, types and rotate helper for the decrypt key generator
package des_pkg;

   localparam int NUM_ROUNDS = 16;

   typedef logic [27:0] half_key_t;
   typedef logic [47:0] subkey_t;
   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   // DES bit numbers (1 = MSB of the 64-bit key) selected by PC1
   localparam int PC1 [0:55] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   // Bit numbers (1 = MSB of C) of the 56-bit C||D selected by PC2
   localparam int PC2 [0:47] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // Encrypt left-shift per round, reused as the right-rotate when leaving round r
   localparam int SHIFT_DEC [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   function automatic half_key_t rotr(input half_key_t x, input logic two);
      return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
   endfunction

endpackage

// File: rtl/des_key_sched_dec_if.sv
// des_key_sched_dec_if: valid/ready subkey stream from the key schedule to the round datapath
interface des_key_sched_dec_if;
   import des_pkg::*;

   subkey_t    subkey;
   logic [4:0] subkey_idx;
   logic       subkey_valid;
   logic       subkey_ready;

   modport master (output subkey, subkey_idx, subkey_valid, input subkey_ready);
   modport slave  (input subkey, subkey_idx, subkey_valid, output subkey_ready);

endinterface

// File: rtl/des_key_sched_dec_pc1_perm.sv
// des_pc1_perm: combinational PC1, 64-bit key to 56-bit C||D (parity bits dropped)
module des_pc1_perm
   import des_pkg::*;
(
   input  logic [63:0] key,
   output logic [55:0] cd
);

   // Parity bits (DES bits 8,16,..,64) are intentionally discarded by PC1
   logic unused_parity;
   assign unused_parity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

   // Gather key bits in PC1 order; DES bit n lives at key[64-n]
   always_comb begin
      cd = '0;
      for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1[i]];
   end

endmodule

// File: rtl/des_key_sched_dec.sv
// des_key_sched_dec: iterative DES decrypt key schedule, emits K16..K1 over a valid/ready stream
// Optional: DES_KEY_PARITY_CHECK_EN adds key_parity_err (odd-parity check of each key byte)
module des_key_sched_dec
   import des_pkg::*;
(
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        start,
   input  logic [63:0] key_in,
   des_key_sched_dec_if.master sk,
   output logic        busy,
   output logic        done
`ifdef DES_KEY_PARITY_CHECK_EN
   ,
   output logic        key_parity_err
`endif
);

   state_t     state;
   half_key_t  c, d;
   logic [4:0] idx;
   logic       valid;
   logic [55:0] cd0;
   logic [55:0] cd;
   subkey_t    pc2_out;

   des_pc1_perm u_pc1 (.key(key_in), .cd(cd0));

   assign cd              = {c, d};
   assign sk.subkey       = pc2_out;
   assign sk.subkey_idx   = idx;
   assign sk.subkey_valid = valid;

   // PC2 on the registered halves; bit n of C||D lives at cd[56-n]
   always_comb begin
      pc2_out = '0;
      for (int i = 0; i < 48; i++) pc2_out[47-i] = cd[56-PC2[i]];
   end

   // Control FSM: load C0/D0, walk rounds 16..1 on each transfer, pulse done
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         c     <= '0;
         d     <= '0;
         idx   <= '0;
         valid <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  {c, d} <= cd0;
                  idx    <= 5'd16;
                  valid  <= 1'b1;
                  busy   <= 1'b1;
                  state  <= EMIT;
               end
            end
            EMIT: begin
               if (sk.subkey_ready) begin
                  if (idx == 5'd1) begin
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     c   <= rotr(c, SHIFT_DEC[idx] == 2);
                     d   <= rotr(d, SHIFT_DEC[idx] == 2);
                     idx <= idx - 5'd1;
                  end
               end
            end
            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DES_KEY_PARITY_CHECK_EN
   logic par_bad;

   // Any byte with even parity violates the DES odd-parity rule
   always_comb begin
      par_bad = 1'b0;
      for (int i = 0; i < 8; i++) par_bad = par_bad | ~^key_in[8*i +: 8];
   end

   // Capture the parity verdict only when a start is accepted
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) key_parity_err <= 1'b0;
      else if (state == IDLE && start) key_parity_err <= par_bad;
   end
`endif

endmodule

// File: doc/des_key_sched_dec.md
Name: des_key_sched_dec

Overview:
- Iterative DES key-schedule generator for the decryption direction.
- Loads a 64-bit key and applies PC1 to form C/D halves (28 bits each).
- Emits the 16 round subkeys in reverse order (K16 first, K1 last) using right rotations, one subkey per valid/ready transfer.
- Sits between the key register and the Feistel round datapath; the decrypt core consumes one subkey per round.

Parameters:
- NUM_ROUNDS, 16, number of subkeys emitted; fixed by DES and not to be overridden.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to load key_in; honoured only when busy=0.
- key_in  input  64  DES key; key_in[63] = DES bit 1; parity bits (DES bits 8,16,…,64) ignored by PC1.
- subkey  output  48  current round subkey; subkey[47] = PC2 output bit 1.
- subkey_idx  output  5  DES round number of subkey (16 down to 1).
- subkey_valid  output  1  subkey/subkey_idx valid.
- subkey_ready  input  1  consumer accepts subkey when high with subkey_valid.
- busy  output  1  high from start acceptance until the last subkey is accepted.
- done  output  1  one-cycle pulse after K1 is accepted.

Behaviour:
- Reset (async, Reset_n=0):
  - FSM=IDLE.
  - C, D, subkey, subkey_idx cleared to 0.
  - subkey_valid, busy, done = 0.
  - Reset mid-run aborts immediately; no further subkeys are emitted.
- FSM states:
  - IDLE: start=1 → latch C0,D0 = PC1(key_in), idx=16, → EMIT.
  - EMIT: subkey_valid=1, subkey=PC2(C,D) from registered C/D.
    - On transfer with idx>1: rotate C and D right by SHIFT_DEC[idx], idx−1, stay in EMIT.
    - On transfer with idx=1: → DONE.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Latency: start accepted at edge t → subkey_valid=1 with K16 after edge t (visible in cycle t+1). K16 = PC2(C0,D0), since the cumulative left shift is 28, which is the identity.
- Right-rotate amount applied when leaving round r (r=16..2): SHIFT_DEC[r] = left-shift amount of encrypt round r, i.e. 1 for r∈{16,9,2}, otherwise 2. Total right rotation over the run is 27; C/D are not restored at end.
- Handshake:
  - subkey, subkey_idx, and subkey_valid are held stable while subkey_valid && !subkey_ready.
  - Back-to-back transfers sustain one subkey per cycle.
  - subkey_valid never drops until a transfer occurs.
- start while busy=1 is ignored; no reload and no error.
- start in the DONE cycle is ignored; it must be reissued in IDLE.
- busy = (state != IDLE) excluding the DONE cycle.
- subkey/subkey_idx retain the last value after completion; they are not meaningful when subkey_valid=0.
- All permutation logic is combinational on registered C/D; no output is combinationally dependent on subkey_ready.

Optional Feature:
- Macro DES_KEY_PARITY_CHECK_EN.
- Defined:
  - Adds output key_parity_err (1 bit, reset 0).
  - On start acceptance, registers 1 if any key_in byte has even parity (DES requires odd parity per byte), else 0.
  - Holds until the next accepted start or reset.
  - Subkey generation proceeds regardless.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package des_pkg:
  - PC1 table (56 entries) and PC2 table (48 entries) as constants.
  - SHIFT_DEC array indexed by round 1..16.
  - Typedef half_key_t (28-bit) and subkey_t (48-bit).
  - FSM state enum {IDLE, EMIT, DONE}.
- Sub-module des_pc1_perm: combinational 64→56 PC1 permutation, instantiated once.
- PC2 implemented as a combinational mapping using des_pkg constants inside this block.

Test Plan:
- Key 0x133457799BBCDFF1, start, subkey_ready held 1:
  - Subkeys appear on 16 consecutive cycles.
  - First: idx=16, subkey=0xCB3D8B0E17F5.
  - Last: idx=1, subkey=0x1B02EFFC7072.
  - done pulses the cycle after the last transfer; busy then 0.
- Same key, subkey_ready toggled pseudo-randomly:
  - subkey/idx stable across stalls.
  - Same 16-value sequence as the encrypt-direction golden model, reversed.
- Key 0x0000000000000000: all 16 subkeys = 0; idx counts 16→1; done pulse.
- start reasserted with key 0xFFFFFFFFFFFFFFFF while busy with idx=10 → ignored; the sequence continues with the original key's K9.
- Reset_n asserted low mid-run at idx=7 → immediately subkey_valid=0, busy=0. A new start afterwards yields K16 one cycle later.
- DES_KEY_PARITY_CHECK_EN defined:
  - Key 0x133457799BBCDFF1 → key_parity_err=1 (bytes such as 0x33 have even parity).
  - Key 0x0101010101010101 → key_parity_err=0.
